pkt_stream_gen: RTL and testbench

Parametrised stimulus source for the packet datapath. It emits multi-beat packets with start-of-packet and end-of-packet flags over a valid/ready stream interface. Packet length, address, type and payload come from a seeded 32-bit LFSR, so every run is reproducible. The block sits in the test harness in front of the router/DUT input port, and it holds each beat stable under backpressure.

---
 rtl/pkt_stream_if.sv | 28 ++
 rtl/pkt_stream_gen.sv | 135 +++++++++++++
 tb/tb_pkt_stream_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_stream_if.sv
// Packet stream bus between the stimulus generator and its sink.
// Handshake: the master raises src_valid with a beat and keeps that beat and
// every flag stable until an accept, i.e. a rising clk edge with
// src_valid && dst_ready. The sink may drive dst_ready at any time; the
// master never waits on it combinationally.
interface pkt_stream_if #(
    parameter int ADDR_W = 2,
    parameter int TYPE_W = 2,
    parameter int DATA_W = 8
);
    logic              src_valid;
    logic              dst_ready;
    logic              sop;
    logic              eop;
    logic [ADDR_W-1:0] dst_addr;
    logic [TYPE_W-1:0] p_type;
    logic [DATA_W-1:0] payload;

    modport master (
        output src_valid, sop, eop, dst_addr, p_type, payload,
        input  dst_ready
    );

    modport slave (
        input  src_valid, sop, eop, dst_addr, p_type, payload,
        output dst_ready
    );
endinterface

// File: rtl/pkt_stream_gen.sv
// Reproducible multi-beat packet source. Length, address, type and payload
// are drawn from a seeded 32-bit Galois LFSR that advances once per beat
// loaded onto the registered outputs.
module pkt_stream_gen #(
    parameter int          ADDR_W  = 2,
    parameter int          TYPE_W  = 2,
    parameter int          DATA_W  = 8,
    parameter int          MAX_LEN = 16,
    parameter int          GAP     = 1,
    parameter logic [31:0] SEED    = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    pkt_stream_if.master s,
    output logic         busy,
    output logic [15:0]  pkt_count,
    output logic [1:0]   state_dbg
);
    // Beat index only needs to reach MAX_LEN-1; keep at least one bit.
    localparam int          IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [7:0]  GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             load_first;
    logic             load_next;
    logic             count_inc;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] first_last;
    logic [IDX_W-1:0] idx_inc;
    logic [7:0]       gap_cnt;

    assign accept     = s.src_valid && s.dst_ready;
    assign lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    // Index of the eop beat for a packet starting with the current LFSR value.
    assign first_last = IDX_W'({16'h0, lfsr[15:0]} % 32'(MAX_LEN));
    assign idx_inc    = beat_idx + 1'b1;

    // Flags derived from the state register only, so no input reaches them.
    assign s.src_valid = (state == ST_SEND);
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and load/count strobes.
    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        count_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    load_first = 1'b1;
                    state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (!s.eop) begin
                        load_next = 1'b1;
                    end else begin
                        count_inc = 1'b1;
                        if (GAP > 0)  state_nxt  = ST_GAP;
                        else if (en)  load_first = 1'b1;
                        else          state_nxt  = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gap timer: restarts from zero on every entry into the gap state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 gap_cnt <= 8'h0;
        else if (state != ST_GAP) gap_cnt <= 8'h0;
        else                     gap_cnt <= gap_cnt + 8'h1;
    end

    // Beat datapath: registers a new beat and advances the LFSR on each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED_EFF;
            s.sop      <= 1'b0;
            s.eop      <= 1'b0;
            s.dst_addr <= '0;
            s.p_type   <= '0;
            s.payload  <= '0;
            beat_idx   <= '0;
            last_idx   <= '0;
        end else if (load_first) begin
            lfsr       <= lfsr_next;
            s.payload  <= lfsr[DATA_W-1:0];
            s.dst_addr <= lfsr[16 +: ADDR_W];
            s.p_type   <= lfsr[24 +: TYPE_W];
            last_idx   <= first_last;
            beat_idx   <= '0;
            s.sop      <= 1'b1;
            s.eop      <= (first_last == '0);
        end else if (load_next) begin
            lfsr       <= lfsr_next;
            s.payload  <= lfsr[DATA_W-1:0];
            beat_idx   <= idx_inc;
            s.sop      <= 1'b0;
            s.eop      <= (idx_inc == last_idx);
        end
    end

    // Completed-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            pkt_count <= 16'h0;
        else if (count_inc) pkt_count <= pkt_count + 16'h1;
    end
endmodule

// File: tb/tb_pkt_stream_gen.sv
// Directed bench for pkt_stream_gen: reset, first packet by hand, stalls,
// en drop, random backpressure against an LFSR model, gap timing and wrap.
module tb_pkt_stream_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_en = 1'b0, b_en = 1'b0, c_en = 1'b0, d_en = 1'b0;
    logic a_busy, b_busy, c_busy, d_busy;
    logic [15:0] a_cnt, b_cnt, c_cnt, d_cnt;
    logic [1:0]  a_st, b_st, c_st, d_st;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr;

    pkt_stream_if a_if();
    pkt_stream_if b_if();
    pkt_stream_if c_if();
    pkt_stream_if d_if();

    pkt_stream_gen u_a (.clk(clk), .rst(rst), .en(a_en), .s(a_if),
                        .busy(a_busy), .pkt_count(a_cnt), .state_dbg(a_st));
    pkt_stream_gen #(.GAP(3)) u_b (.clk(clk), .rst(rst), .en(b_en), .s(b_if),
                        .busy(b_busy), .pkt_count(b_cnt), .state_dbg(b_st));
    pkt_stream_gen #(.GAP(0)) u_c (.clk(clk), .rst(rst), .en(c_en), .s(c_if),
                        .busy(c_busy), .pkt_count(c_cnt), .state_dbg(c_st));
    pkt_stream_gen #(.MAX_LEN(1), .GAP(0), .SEED(32'h0)) u_d (.clk(clk), .rst(rst),
                        .en(d_en), .s(d_if), .busy(d_busy), .pkt_count(d_cnt),
                        .state_dbg(d_st));

    // Clock and reset.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Beat packing: {sop, eop, addr[1:0], type[1:0], payload[7:0]}.
    function automatic logic [31:0] beat_a();
        return {18'b0, a_if.sop, a_if.eop, a_if.dst_addr, a_if.p_type, a_if.payload};
    endfunction

    // Model: append the beats of the next packet (defaults) to exp_q.
    task automatic gen_packet();
        logic [31:0] v0;
        int len;
        v0  = m_lfsr;
        len = int'(v0[15:0] % 16'd16) + 1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({18'b0, (i == 0), (i == len - 1), v0[17:16], v0[25:24], m_lfsr[7:0]});
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    initial begin
        int n;
        int cnt;
        int idle;
        int eops;
        logic stalled;
        logic prev_eop;
        logic [31:0] held;

        a_if.dst_ready = 1'b0;
        b_if.dst_ready = 1'b0;
        c_if.dst_ready = 1'b0;
        d_if.dst_ready = 1'b0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_beat", {31'b0, a_if.src_valid} | beat_a(), 32'h0);
        check("rst_cnt", 32'(a_cnt), 32'h0);
        check("rst_busy", {31'b0, a_busy}, 32'h0);
        check("rst_state", 32'(a_st), 32'h0);
        rst = 1'b0;

        // en low: nothing is emitted.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_if.src_valid) cnt++;
        end
        check("idle_no_valid", 32'(cnt), 32'h0);

        // First packet, SEED=1: beat0 payload 01 (len 2), beat1 payload 03.
        a_en = 1'b1;
        tick();
        check("p1_valid", {31'b0, a_if.src_valid}, 32'h1);
        check("p1_beat0", beat_a(), 32'h2001);
        a_en = 1'b0;
        // Five stalled cycles: the beat holds regardless of en.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p1_stall", {a_if.src_valid, beat_a()[30:0]}, 32'h8000_2001);
        end
        a_if.dst_ready = 1'b1;
        tick();
        check("p1_beat1", beat_a(), 32'h1003);
        check("p1_cnt_mid", 32'(a_cnt), 32'h0);
        tick();
        check("p1_cnt", 32'(a_cnt), 32'h1);
        check("p1_gap_valid", {31'b0, a_if.src_valid}, 32'h0);
        check("p1_gap_busy", {31'b0, a_busy}, 32'h1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_if.src_valid) cnt++;
        end
        check("p1_after_quiet", 32'(cnt), 32'h0);
        check("p1_after_busy", {31'b0, a_busy}, 32'h0);

        // Model resumes after the two loads of packet 1.
        m_lfsr = 32'hC030_0002;

        // en dropped after sop: packet still completes, then silence.
        gen_packet();
        a_en = 1'b1;
        tick();
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (a_if.src_valid) begin
                if (a_if.sop) a_en = 1'b0;
                check("p2_beat", beat_a(), exp_q.pop_front());
            end
            tick();
            n++;
        end
        check("p2_done", 32'(exp_q.size()), 32'h0);
        check("p2_cnt", 32'(a_cnt), 32'h2);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_if.src_valid) cnt++;
        end
        check("p2_quiet", 32'(cnt), 32'h0);

        // Random backpressure over 20 packets against the model.
        for (int i = 0; i < 20; i++) gen_packet();
        a_en = 1'b1;
        stalled = 1'b0;
        held = '0;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            if (stalled) check("sb_hold", {a_if.src_valid, beat_a()[30:0]}, {1'b1, held[30:0]});
            a_if.dst_ready = ($urandom_range(0, 3) != 0);
            if (a_if.src_valid && a_if.dst_ready) begin
                check("sb_beat", beat_a(), exp_q.pop_front());
                stalled = 1'b0;
            end else if (a_if.src_valid) begin
                stalled = 1'b1;
                held = beat_a();
            end else begin
                stalled = 1'b0;
            end
            tick();
            n++;
        end
        a_en = 1'b0;
        check("sb_done", 32'(exp_q.size()), 32'h0);
        check("sb_cnt", 32'(a_cnt), 32'd22);

        // GAP=3: four idle cycles between the eop accept and the next sop.
        b_if.dst_ready = 1'b1;
        b_en = 1'b1;
        tick();
        n = 0;
        while (!(b_if.src_valid && b_if.eop) && n < 100) begin
            tick();
            n++;
        end
        tick();
        idle = 0;
        while (!b_if.src_valid && idle < 50) begin
            idle++;
            tick();
        end
        check("gap3_idle", 32'(idle), 32'd4);
        check("gap3_sop", {31'b0, b_if.sop}, 32'h1);
        b_en = 1'b0;

        // GAP=0: every cycle valid, each beat after an eop is a sop.
        c_if.dst_ready = 1'b1;
        c_en = 1'b1;
        tick();
        idle = 0;
        eops = 0;
        cnt = 0;
        prev_eop = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!c_if.src_valid) idle++;
            if (prev_eop && !c_if.sop) cnt++;
            if (c_if.src_valid && c_if.eop) eops++;
            prev_eop = c_if.src_valid && c_if.eop;
            tick();
        end
        c_en = 1'b0;
        check("gap0_idle", 32'(idle), 32'h0);
        check("gap0_sop_follow", 32'(cnt), 32'h0);
        check("gap0_eops", {31'b0, (eops >= 2)}, 32'h1);

        // Asynchronous reset mid-packet clears outputs without a clock edge.
        a_if.dst_ready = 1'b0;
        a_en = 1'b1;
        n = 0;
        while (!a_if.src_valid && n < 20) begin
            tick();
            n++;
        end
        check("mid_valid", {31'b0, a_if.src_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_beat", {31'b0, a_if.src_valid} | beat_a(), 32'h0);
        check("mid_rst_cnt", 32'(a_cnt), 32'h0);
        check("mid_rst_busy", {31'b0, a_busy}, 32'h0);
        a_en = 1'b0;
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_if.src_valid) cnt++;
        end
        check("mid_quiet", 32'(cnt), 32'h0);

        // MAX_LEN=1, SEED=0 (runs as 1): 70000 single-beat packets, count wraps.
        d_if.dst_ready = 1'b1;
        d_en = 1'b1;
        tick();
        check("wrap_first_payload", 32'(d_if.payload), 32'h1);
        cnt = 0;
        for (int i = 0; i < 70000; i++) begin
            if (d_if.src_valid && d_if.sop && d_if.eop) cnt++;
            tick();
        end
        d_en = 1'b0;
        check("wrap_sop_eop", 32'(cnt), 32'd70000);
        check("wrap_cnt", 32'(d_cnt), 32'd4464);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
